// File: rtl/hybrid_ni_tdm_injector_pkg.sv
// Shared NoC helpers: slot-index sizing and flit parity, also used by the fault-detection side.
package hybrid_ni_tdm_injector_pkg;

    localparam int unsigned MaxFlitWidth = 256;

    typedef enum logic [1:0] {
        SrcIdle,
        SrcTdm,
        SrcBe
    } out_src_e;

    function automatic int unsigned slot_idx_width(input int unsigned lut_size);
        return (lut_size > 1) ? $clog2(lut_size) : 1;
    endfunction

    // Even parity of every payload bit j with j mod parity_bits == k.
    function automatic logic parity_bit(input logic [MaxFlitWidth-1:0] payload,
                                        input int unsigned flit_width,
                                        input int unsigned parity_bits,
                                        input int unsigned k);
        logic p;
        p = 1'b0;
        for (int unsigned j = 0; j < MaxFlitWidth; j++) begin
            if (parity_bits != 0 && j < flit_width) begin
                if ((j % parity_bits) == k) begin
                    p = p ^ payload[j[7:0]];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tdm_slot_fifo.sv
// TDM staging FIFO holding flit+last; count-based full/empty, no fall-through.
module tdm_slot_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_flit,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_flit,
    output logic             head_last,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Full is judged before any pop in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_last, head_flit} = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= {push_last, push_flit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hybrid_ni_tdm_injector.sv
// NI-side injector: TDM flits sent in owned slots from a staging FIFO, BE traffic fills the rest.
module hybrid_ni_tdm_injector
    import hybrid_ni_tdm_injector_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH  = 32,
    parameter int unsigned PARITY_BITS = 0,
    parameter int unsigned LUT_SIZE    = 16,
    parameter int unsigned SLOT_OFFSET = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FLIT_WIDTH-1:0]               tdm_in_flit,
    input  logic                                tdm_in_last,
    input  logic                                tdm_in_valid,
    output logic                                tdm_in_ready,
    input  logic [FLIT_WIDTH-1:0]               be_in_flit,
    input  logic                                be_in_last,
    input  logic                                be_in_valid,
    output logic                                be_in_ready,
    output logic [PARITY_BITS+FLIT_WIDTH-1:0]   out_flit,
    output logic                                out_last,
    output logic                                tdm_out_valid,
    output logic                                be_out_valid,
    input  logic                                be_out_ready,
    input  logic [slot_idx_width(LUT_SIZE)-1:0] lut_conf_slot,
    input  logic                                lut_conf_data,
    input  logic                                lut_conf_valid
);

    localparam int unsigned SlotW = slot_idx_width(LUT_SIZE);

    logic [SlotW-1:0]      slot_q;
    logic [LUT_SIZE-1:0]   lut_q;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  head_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  tdm_send;
    out_src_e              src;
    logic [FLIT_WIDTH-1:0] out_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SlotW'(SLOT_OFFSET);
            lut_q  <= '0;
        end else begin
            slot_q <= slot_q + SlotW'(1);
            if (lut_conf_valid) begin
                lut_q[lut_conf_slot] <= lut_conf_data;
            end
        end
    end

    tdm_slot_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tdm_in_valid && tdm_in_ready),
        .push_flit (tdm_in_flit),
        .push_last (tdm_in_last),
        .pop       (tdm_send),
        .head_flit (head_flit),
        .head_last (head_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tdm_in_ready = !fifo_full;
    // Gated by rst so a stale table/FIFO cannot emit during the reset cycle.
    assign tdm_send     = !rst && lut_q[slot_q] && !fifo_empty;

    always_comb begin
        src = SrcIdle;
        if (tdm_send) begin
            src = SrcTdm;
        end else if (be_in_valid) begin
            src = SrcBe;
        end
        out_payload = '0;
        out_last    = 1'b0;
        unique case (src)
            SrcTdm: begin
                out_payload = head_flit;
                out_last    = head_last;
            end
            SrcBe: begin
                out_payload = be_in_flit;
                out_last    = be_in_last;
            end
            default: ;
        endcase
        tdm_out_valid = tdm_send;
        be_out_valid  = !tdm_send && be_in_valid;
        be_in_ready   = !tdm_send && be_out_ready;
    end

    if (PARITY_BITS > 0) begin : g_parity
        logic [PARITY_BITS-1:0] tdm_parity;
        logic [PARITY_BITS-1:0] par_sel;
        for (genvar k = 0; k < PARITY_BITS; k++) begin : g_bit
            assign tdm_parity[k] = parity_bit(MaxFlitWidth'(head_flit), FLIT_WIDTH,
                                              PARITY_BITS, k);
        end
        assign par_sel  = tdm_send ? tdm_parity : '0;
        assign out_flit = {par_sel, out_payload};
    end else begin : g_no_parity
        assign out_flit = out_payload;
    end

endmodule
